// File: rtl/aes_key_expander_if.sv
// Key-expander bus: init/key handshake, round-key read port and shared S-box word port.
`timescale 1ns/1ps
interface aes_key_expander_if;
  logic         init;
  logic [255:0] key;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  modport master (
    output init, key, keylen, round, new_sboxw,
    input  round_key, ready, sboxw
  );

  modport slave (
    input  init, key, keylen, round, new_sboxw,
    output round_key, ready, sboxw
  );
endinterface

// File: rtl/aes_key_expander.sv
// AES-128/256 key expander: one round key per cycle into a 15-entry key memory.
// Optional macro AES_KEY_EXP_RDREG_EN registers the round_key read port.
`timescale 1ns/1ps
module aes_key_expander #(
  parameter logic [3:0]  AES128_ROUNDS = 4'ha,
  parameter logic [3:0]  AES256_ROUNDS = 4'he,
  parameter int unsigned KEY_MEM_DEPTH = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_key_expander_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, INIT, GEN, DONE} state_t;

  state_t       state, state_next;
  logic [255:0] key_reg;
  logic         keylen_reg;
  logic [127:0] mem [KEY_MEM_DEPTH];
  logic [7:0]   rcon;
  logic [3:0]   round_ctr;
  logic         ready_reg;

  logic [3:0]   last_idx;
  logic [127:0] prev, prev2, base;
  logic [31:0]  w3, t, k0, k1, k2, k3, sboxw_int;
  logic         rot_step;
  logic [7:0]   rcon_next;
  logic [127:0] rd_data;

  assign last_idx  = keylen_reg ? AES256_ROUNDS : AES128_ROUNDS;
  // AES-256 odd rounds skip RotWord and rcon; AES-128 rotates every round.
  assign rot_step  = !keylen_reg || !round_ctr[0];
  assign rcon_next = {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}});

  always_comb begin
    prev  = '0;
    prev2 = '0;
    if (state == GEN) begin
      prev = mem[round_ctr - 4'd1];
      if (keylen_reg)
        prev2 = mem[round_ctr - 4'd2];
    end
  end

  assign w3   = prev[31:0];
  assign base = keylen_reg ? prev2 : prev;
  assign t    = bus.new_sboxw ^ (rot_step ? {rcon, 24'h0} : 32'h0);
  assign k0   = base[127:96] ^ t;
  assign k1   = base[95:64]  ^ k0;
  assign k2   = base[63:32]  ^ k1;
  assign k3   = base[31:0]   ^ k2;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    sboxw_int  = '0;
    case (state)
      IDLE: if (bus.init) state_next = INIT;
      INIT: state_next = GEN;
      GEN: begin
        sboxw_int = rot_step ? {w3[23:0], w3[31:24]} : w3;
        if (round_ctr == last_idx)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.sboxw = sboxw_int;
  assign bus.ready = ready_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_reg  <= 1'b1;
      rcon       <= 8'h8d;
      round_ctr  <= '0;
      key_reg    <= '0;
      keylen_reg <= 1'b0;
      mem        <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (bus.init) begin
            key_reg    <= bus.key;
            keylen_reg <= bus.keylen;
            ready_reg  <= 1'b0;
          end
        end
        INIT: begin
          mem[0] <= key_reg[255:128];
          if (keylen_reg)
            mem[1] <= key_reg[127:0];
          rcon      <= 8'h01;
          round_ctr <= keylen_reg ? 4'd2 : 4'd1;
        end
        GEN: begin
          mem[round_ctr] <= {k0, k1, k2, k3};
          round_ctr      <= round_ctr + 4'd1;
          if (rot_step)
            rcon <= rcon_next;
        end
        DONE: ready_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.round <= last_idx)
      rd_data = mem[bus.round];
  end

`ifdef AES_KEY_EXP_RDREG_EN
  logic [127:0] round_key_reg;

  always_ff @(posedge clk) begin
    if (reset)
      round_key_reg <= '0;
    else
      round_key_reg <= rd_data;
  end

  assign bus.round_key = round_key_reg;
`else
  assign bus.round_key = rd_data;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: directed vector table, corner sequences, random keys vs FIPS-197 model.
`timescale 1ns/1ps
module tb_aes_key_expander;

  logic clk = 1'b0;
  logic reset;
  int   checks;
  int   errors;

  aes_key_expander_if bus();

  aes_key_expander dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb bus.new_sboxw = sub_word(bus.sboxw);

  logic [127:0] model_rk [16];

  task automatic model_expand(input logic [255:0] k, input logic kl);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 16; r++) begin
      model_rk[r] = '0;
      if (r <= nr) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_round(input logic [3:0] r, output logic [127:0] v);
    @(negedge clk);
    bus.round = r;
    @(posedge clk);
    #1;
    v = bus.round_key;
  endtask

  // mode 0 plain, 1 init while busy, 2 init during DONE, 3 reset mid-GEN
  task automatic expand(input logic [255:0] k, input logic kl, input int mode, output int lat);
    @(negedge clk);
    bus.init   = 1'b1;
    bus.key    = k;
    bus.keylen = kl;
    @(posedge clk);
    #1;
    bus.init = 1'b0;
    bus.key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!bus.ready && lat < 100) begin
      lat++;
      if (mode == 1 && lat == 3) begin
        bus.init = 1'b1; bus.key = ~k; bus.keylen = ~kl;
      end else if (mode == 1 && lat == 4) begin
        bus.init = 1'b0;
      end
      if (mode == 2 && lat == (kl ? 15 : 12)) bus.init = 1'b1;
      if (mode == 3 && lat == 6) reset = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.init = 1'b0;
  endtask

  typedef struct {
    logic         keylen;
    logic [255:0] key;
    logic [3:0]   round;
    logic [127:0] exp;
  } vec_t;

  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_a5a5a5a5deadbeef0123456789abcdef;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] v;
    logic [255:0] cur_key;
    logic         cur_len;
    logic [255:0] rk;
    logic         rl;
    int           lat;
    bit           have;

    vecs[0] = '{1'b0, K128, 4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[1] = '{1'b0, K128, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[2] = '{1'b0, K128, 4'd11, 128'h0};
    vecs[3] = '{1'b0, K128, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};
    vecs[4] = '{1'b1, K256, 4'd1,  128'h101112131415161718191a1b1c1d1e1f};
    vecs[5] = '{1'b1, K256, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    vecs[6] = '{1'b1, K256, 4'd15, 128'h0};
    vecs[7] = '{1'b0, K128, 4'd14, 128'h0};

    checks = 0; errors = 0;
    reset = 1'b1; bus.init = 1'b0; bus.key = '0; bus.keylen = 1'b0; bus.round = '0;

    // reset held two edges
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 256'(bus.ready), 256'(1'b1));
    check("reset_sboxw", 256'(bus.sboxw), 256'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 16; r++) begin
      read_round(4'(r), v);
      check($sformatf("reset_rk%0d", r), 256'(v), 256'h0);
    end

    // directed vector table
    have = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!have || vecs[i].key != cur_key || vecs[i].keylen != cur_len) begin
        expand(vecs[i].key, vecs[i].keylen, 0, lat);
        check("latency", 256'(lat), vecs[i].keylen ? 256'd15 : 256'd12);
        cur_key = vecs[i].key; cur_len = vecs[i].keylen; have = 1'b1;
      end
      read_round(vecs[i].round, v);
      check($sformatf("vec%0d_r%0d", i, vecs[i].round), 256'(v), 256'(vecs[i].exp));
    end

    // init while busy is ignored
    model_expand(K128, 1'b0);
    expand(K128, 1'b0, 1, lat);
    check("busy_latency", 256'(lat), 256'd12);
    for (int r = 0; r < 12; r++) begin
      read_round(4'(r), v);
      check($sformatf("busy_rk%0d", r), 256'(v), 256'(model_rk[r]));
    end

    // init during DONE is not accepted
    expand(K256, 1'b1, 2, lat);
    check("done_latency", 256'(lat), 256'd15);
    @(posedge clk);
    #1;
    check("done_init_ignored", 256'(bus.ready), 256'(1'b1));

    // reset in the middle of an AES-256 expansion
    expand(K256, 1'b1, 3, lat);
    check("midreset_latency", 256'(lat), 256'd6);
    check("midreset_ready", 256'(bus.ready), 256'(1'b1));
    check("midreset_sboxw", 256'(bus.sboxw), 256'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 16; r++) begin
      read_round(4'(r), v);
      check($sformatf("midreset_rk%0d", r), 256'(v), 256'h0);
    end
    expand(K128, 1'b0, 0, lat);
    check("fresh_latency", 256'(lat), 256'd12);
    read_round(4'd1, v);
    check("fresh_r1", 256'(v), 256'(128'hd6aa74fdd2af72fadaa678f1d6ab76fe));
    read_round(4'd10, v);
    check("fresh_r10", 256'(v), 256'(128'h13111d7fe3944a17f307a78b4d2b30c5));

    // read timing: comb read is immediate, registered read lags one edge
    model_expand(K128, 1'b0);
    read_round(4'd0, v);
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      bus.round = 4'(r);
      #1;
`ifdef AES_KEY_EXP_RDREG_EN
      check($sformatf("rdreg_hold%0d", r), 256'(bus.round_key), 256'(model_rk[r-1]));
`else
      check($sformatf("comb_read%0d", r), 256'(bus.round_key), 256'(model_rk[r]));
`endif
      @(posedge clk);
      #1;
      check($sformatf("read_after_edge%0d", r), 256'(bus.round_key), 256'(model_rk[r]));
    end

    // random keys against the reference model
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rl = 1'($urandom_range(0, 1));
      model_expand(rk, rl);
      expand(rk, rl, 0, lat);
      check("rand_latency", 256'(lat), rl ? 256'd15 : 256'd12);
      check("rand_idle_sboxw", 256'(bus.sboxw), 256'h0);
      for (int r = 0; r < 16; r++) begin
        read_round(4'(r), v);
        check($sformatf("rand%0d_rk%0d", n, r), 256'(v), 256'(model_rk[r]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
